// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RISC-V core's fetch front end.
//   BHW_WORD          : bus transfer-size code for a 32-bit access
//   HALT_WORD_DEFAULT : instruction word that stops prefetching
//   fetch_state_e     : prefetch FSM state encoding
package cpu_pkg;

    localparam logic [2:0]  BHW_WORD          = 3'b010;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'd255;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_HALT    = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of {pc, instruction} pairs for the prefetch queue.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push         : write i_push_data at tail (ignored on flush)
//   i_push_data    : {pc[31:0], instr[31:0]}
//   i_pop          : advance head (ignored when empty or on flush)
//   i_flush        : empty the queue; wins over push and pop
//   o_rd_data      : head entry, no read latency
//   o_count        : number of valid entries
module fetch_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [63:0]                i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [63:0]                o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_eff;
    logic          pop_eff;

    // The producer guarantees a free slot before pushing, so no full check.
    assign push_eff = i_push & ~i_flush;
    assign pop_eff  = i_pop & ~i_flush & (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_eff) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop_eff) begin
                head_d = head_q + AW'(1);
            end
            unique case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_eff) begin
                mem_q[tail_q] <= i_push_data;
            end
        end
    end

    assign o_rd_data = mem_q[head_q];
    assign o_count   = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch front end: issues sequential word reads ahead of the
// core and buffers {pc, instr} pairs in a show-ahead queue. A redirect
// flushes the queue, reloads the fetch PC and drops any in-flight response.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_bus_grant          : arbiter allows a request this cycle
//   o_bus_DV             : one-cycle read request strobe
//   o_bus_address        : word-aligned request address
//   o_bhw, o_write_notread, o_bus_data : fixed word-read attributes
//   i_bus_data, i_bus_DV : read response
//   o_instr, o_instr_pc  : head entry of the queue
//   o_instr_valid        : queue non-empty
//   i_instr_ready        : core consumes the head entry
//   i_redirect           : flush and restart fetch at i_redirect_pc
//   o_halted             : HALT_WORD was enqueued; prefetch stopped
module instr_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_bus_grant,
    output logic        o_bus_DV,
    output logic [31:0] o_bus_address,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    output logic [31:0] o_bus_data,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_halted
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          push;
    logic          flush;
    logic          pop;
    logic [63:0]   head_entry;
    logic [CW-1:0] count;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        o_bus_DV   = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_bus_grant && !i_redirect && (count < DEPTH_C)) begin
                    o_bus_DV = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_bus_DV) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (i_bus_data == HALT_WORD) ? S_HALT : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (i_bus_DV) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above, including a same-cycle push.
        if (i_redirect) begin
            flush      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = i_redirect_pc & ~32'h3;
            unique case (state_q)
                // A request is still outstanding unless its data lands now.
                S_WAIT:    state_d = i_bus_DV ? S_IDLE : S_DISCARD;
                S_DISCARD: state_d = S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign pop = i_instr_ready & o_instr_valid;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data ({fetch_pc_q, i_bus_data}),
        .i_pop       (pop),
        .i_flush     (flush),
        .o_rd_data   (head_entry),
        .o_count     (count)
    );

    assign o_bus_address   = fetch_pc_q;
    assign o_bhw           = BHW_WORD;
    assign o_write_notread = 1'b0;
    assign o_bus_data      = 32'd0;
    assign o_instr         = head_entry[31:0];
    assign o_instr_pc      = head_entry[63:32];
    assign o_instr_valid   = (count != '0);
    assign o_halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        grant;
    logic        bus_dv_out;
    logic [31:0] bus_addr;
    logic [2:0]  bhw;
    logic        wnr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_dv_in;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    // Memory model: auto mode answers every request one cycle later.
    logic        auto_en;
    logic        auto_dv;
    logic [31:0] auto_data;
    logic        man_dv;
    logic [31:0] man_data;
    logic [31:0] halt_addr;

    int checks   = 0;
    int failures = 0;
    int nreq;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr) return 32'h0000_00FF;
        return (a << 8) | 32'h13;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_dv   <= 1'b0;
            auto_data <= 32'd0;
        end else begin
            auto_dv   <= bus_dv_out;
            auto_data <= mem_word(bus_addr);
        end
    end

    assign bus_dv_in = auto_en ? auto_dv : man_dv;
    assign bus_rdata = auto_en ? auto_data : man_data;

    instr_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_bus_grant     (grant),
        .o_bus_DV        (bus_dv_out),
        .o_bus_address   (bus_addr),
        .o_bhw           (bhw),
        .o_write_notread (wnr),
        .o_bus_data      (bus_wdata),
        .i_bus_data      (bus_rdata),
        .i_bus_DV        (bus_dv_in),
        .o_instr         (instr),
        .o_instr_pc      (instr_pc),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (ready),
        .i_redirect      (redirect),
        .i_redirect_pc   (redirect_pc),
        .o_halted        (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bus_DV"}, {31'd0, bus_dv_out}, 32'd0);
        check({tag, " bus_addr"}, bus_addr, 32'd0);
        check({tag, " instr"}, instr, 32'd0);
        check({tag, " instr_pc"}, instr_pc, 32'd0);
        check({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, " halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        grant       = 1'b0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        auto_en     = 1'b1;
        man_dv      = 1'b0;
        man_data    = 32'd0;
        halt_addr   = 32'hFFFF_FFFC;

        // Reset values and constant bus attributes
        #12;
        check_reset_outputs("reset");
        check("bhw", {29'd0, bhw}, 32'd2);
        check("write_notread", {31'd0, wnr}, 32'd0);
        check("bus_wdata", bus_wdata, 32'd0);

        // First fetch after reset release
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        grant = 1'b1;
        #1;
        check("first req DV", {31'd0, bus_dv_out}, 32'd1);
        check("first req addr", bus_addr, 32'd0);
        tick();
        check("wait no DV", {31'd0, bus_dv_out}, 32'd0);
        check("wait not valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("first valid", {31'd0, instr_valid}, 32'd1);
        check("first instr", instr, 32'h0000_0013);
        check("first pc", instr_pc, 32'd0);

        // Fill to DEPTH with no pops: three more requests, then silence
        nreq     = 0;
        exp_addr = 32'h4;
        for (int i = 0; i < 12; i++) begin
            if (bus_dv_out) begin
                check("fill addr", bus_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                nreq++;
            end
            tick();
        end
        check("fill req count", nreq, 32'd3);
        check("full no DV", {31'd0, bus_dv_out}, 32'd0);
        check("full head pc", instr_pc, 32'd0);

        // One pop frees a slot; next request at 0x10
        ready = 1'b1;
        tick();
        ready = 1'b0;
        #1;
        check("pop head pc", instr_pc, 32'h4);
        check("pop head instr", instr, 32'h0000_0413);
        check("refill DV", {31'd0, bus_dv_out}, 32'd1);
        check("refill addr", bus_addr, 32'h10);
        tick();
        tick();

        // Redirect while waiting; stale response dropped
        auto_en     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("redirect blocks DV", {31'd0, bus_dv_out}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("flush empties", {31'd0, instr_valid}, 32'd0);
        check("req after flush", bus_addr, 32'h40);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        #1;
        check("discard no DV", {31'd0, bus_dv_out}, 32'd0);
        check("redirect pc aligned", bus_addr, 32'h100);
        tick();
        tick();
        check("discard still no DV", {31'd0, bus_dv_out}, 32'd0);
        man_dv   = 1'b1;
        man_data = 32'hDEAD_BEEF;
        tick();
        man_dv = 1'b0;
        #1;
        check("stale dropped", {31'd0, instr_valid}, 32'd0);
        check("post discard DV", {31'd0, bus_dv_out}, 32'd1);
        check("post discard addr", bus_addr, 32'h100);
        tick();
        man_dv   = 1'b1;
        man_data = 32'h1234_5678;
        tick();
        man_dv = 1'b0;
        #1;
        check("redirect entry valid", {31'd0, instr_valid}, 32'd1);
        check("redirect entry pc", instr_pc, 32'h100);
        check("redirect entry instr", instr, 32'h1234_5678);

        // Push and pop in the same cycle at count=1
        tick();
        man_dv   = 1'b1;
        man_data = 32'hAAAA_0000;
        ready    = 1'b1;
        tick();
        man_dv = 1'b0;
        ready  = 1'b0;
        grant  = 1'b0;
        #1;
        check("pushpop valid", {31'd0, instr_valid}, 32'd1);
        check("pushpop head pc", instr_pc, 32'h104);
        check("pushpop head instr", instr, 32'hAAAA_0000);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        #1;
        check("count was one", {31'd0, instr_valid}, 32'd0);
        // Pop while empty must not disturb head or count
        ready = 1'b1;
        tick();
        ready = 1'b0;
        #1;
        check("empty pop valid", {31'd0, instr_valid}, 32'd0);
        grant = 1'b1;
        #1;
        check("after empty pop addr", bus_addr, 32'h108);
        tick();
        grant    = 1'b0;
        man_dv   = 1'b1;
        man_data = 32'h5555_5555;
        tick();
        man_dv = 1'b0;
        #1;
        check("after empty pop valid", {31'd0, instr_valid}, 32'd1);
        check("after empty pop pc", instr_pc, 32'h108);
        check("after empty pop instr", instr, 32'h5555_5555);

        // Halt word at 0x8 stops prefetch
        grant       = 1'b1;
        auto_en     = 1'b1;
        halt_addr   = 32'h8;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        #1;
        nreq     = 0;
        exp_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if (bus_dv_out) begin
                check("halt run addr", bus_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                nreq++;
            end
            tick();
        end
        check("halt req count", nreq, 32'd3);
        check("halted", {31'd0, halted}, 32'd1);
        check("halted no DV", {31'd0, bus_dv_out}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("drain pc", instr_pc, 32'(4 * k));
            check("drain instr", instr, mem_word(32'(4 * k)));
            ready = 1'b1;
            tick();
            ready = 1'b0;
            #1;
        end
        check("drained", {31'd0, instr_valid}, 32'd0);
        check("still halted", {31'd0, halted}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        #1;
        check("unhalted", {31'd0, halted}, 32'd0);
        check("restart DV", {31'd0, bus_dv_out}, 32'd1);
        check("restart addr", bus_addr, 32'h0);

        // Async reset mid-wait; late response ignored
        auto_en = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        grant = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        man_dv   = 1'b1;
        man_data = 32'h0000_0777;
        tick();
        man_dv = 1'b0;
        #1;
        check_reset_outputs("late resp");
        grant = 1'b1;
        #1;
        check("post reset DV", {31'd0, bus_dv_out}, 32'd1);
        check("post reset addr", bus_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
